// File: rtl/time_pkg.sv
// Shared definitions for the time-of-day / stopwatch counter chain.
//   MOD_CSEC..MOD_HOUR : default moduli of the four stages
//   stage_op_e         : per-stage step command (hold / +1 / -1)
//   cnt_w()            : register width needed to hold 0..m-1 (at least 1 bit)
package time_pkg;

    localparam int MOD_CSEC = 100;
    localparam int MOD_SEC  = 60;
    localparam int MOD_MIN  = 60;
    localparam int MOD_HOUR = 24;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        INC  = 2'd1,
        DEC  = 2'd2
    } stage_op_e;

    function automatic int cnt_w(input int m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/mod_stage_counter.sv
// One modulo-MOD counter stage of the time chain.
//   clk, reset : clock, asynchronous active-high reset (value -> PRESET)
//   op         : NONE / INC / DEC step request for this cycle
//   clear      : synchronous return to PRESET (highest synchronous priority)
//   load       : synchronous parallel load of ld_val, saturated to MOD-1
//   value      : current stage value
//   wrap       : combinational; this cycle's op crosses the modulus boundary
//                (MOD-1 -> 0 on INC, 0 -> MOD-1 on DEC), used as carry/borrow
module mod_stage_counter
    import time_pkg::*;
#(
    parameter  int MOD    = 60,
    parameter  int PRESET = 0,
    localparam int W      = cnt_w(MOD)
) (
    input  logic         clk,
    input  logic         reset,
    input  stage_op_e    op,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V    = W'(MOD - 1);
    localparam logic [W-1:0] PRESET_V = W'(PRESET);
    localparam logic [W:0]   MOD_V    = (W + 1)'(MOD);

    // Out-of-range load values clamp to the top of the range.
    function automatic logic [W-1:0] sat_load(input logic [W-1:0] v);
        return ({1'b0, v} >= MOD_V) ? MAX_V : v;
    endfunction

    assign wrap = ((op == INC) && (value == MAX_V)) ||
                  ((op == DEC) && (value == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= PRESET_V;
        end else if (clear) begin
            value <= PRESET_V;
        end else if (load) begin
            value <= sat_load(ld_val);
        end else begin
            case (op)
                INC:     value <= wrap ? '0    : value + 1'b1;
                DEC:     value <= wrap ? MAX_V : value - 1'b1;
                default: value <= value;
            endcase
        end
    end

endmodule

// File: rtl/time_counter_chain.sv
// Four-stage time counter (centi-second, second, minute, hour) with an
// internal tick prescaler, up/down counting, parallel load, per-stage edit,
// countdown halt-at-zero with a done pulse, and an alarm comparator.
//   clk, reset        : clock, asynchronous active-high reset
//   run               : enables the prescaler (and therefore counting)
//   dir               : 0 = count up, 1 = count down
//   clear             : all stages to preset, prescaler to 0
//   load, ld_s0..ld_s3: parallel load (saturated to modulus-1)
//   edit_sel, edit_up, edit_dn : +/-1 on one stage, only while run = 0
//   alarm_en, al_s1..al_s3     : alarm compare on sec/min/hour
//   s0..s3            : stage values
//   tick_out          : registered one-cycle stage-0 tick
//   done              : one-cycle pulse after a down-tick reaches all zero
//   alarm             : one-cycle pulse on the rising edge of the match
module time_counter_chain
    import time_pkg::*;
#(
    parameter  int CLK_HZ       = 100_000_000,
    parameter  int TICK_HZ      = 100,
    parameter  int MOD0         = MOD_CSEC,
    parameter  int MOD1         = MOD_SEC,
    parameter  int MOD2         = MOD_MIN,
    parameter  int MOD3         = MOD_HOUR,
    parameter  int PRESET3      = 0,
    parameter  int EDIT_CARRY   = 0,
    parameter  int HALT_AT_ZERO = 1,
    localparam int W0           = cnt_w(MOD0),
    localparam int W1           = cnt_w(MOD1),
    localparam int W2           = cnt_w(MOD2),
    localparam int W3           = cnt_w(MOD3)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          dir,
    input  logic          clear,
    input  logic          load,
    input  logic [W0-1:0] ld_s0,
    input  logic [W1-1:0] ld_s1,
    input  logic [W2-1:0] ld_s2,
    input  logic [W3-1:0] ld_s3,
    input  logic [1:0]    edit_sel,
    input  logic          edit_up,
    input  logic          edit_dn,
    input  logic          alarm_en,
    input  logic [W1-1:0] al_s1,
    input  logic [W2-1:0] al_s2,
    input  logic [W3-1:0] al_s3,
    output logic [W0-1:0] s0,
    output logic [W1-1:0] s1,
    output logic [W2-1:0] s2,
    output logic [W3-1:0] s3,
    output logic          tick_out,
    output logic          done,
    output logic          alarm
);

    localparam int            TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int            PW       = cnt_w(TICK_DIV);
    localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);

    logic [PW-1:0] ps_cnt;
    logic          all_zero;
    logic          halt;
    logic          tick_go;
    logic          edit_ok;
    logic          chain_on;
    stage_op_e     tick_op;
    stage_op_e     edit_op;
    stage_op_e     chain_op;
    stage_op_e     op0, op1, op2, op3;
    logic          wrap0, wrap1, wrap2, wrap3_unused;
    logic          match;
    logic          match_p0;
    logic          dn_step_p0;

    // ---- Stage p0: prescaler -> registered tick ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_cnt   <= '0;
            tick_out <= 1'b0;
        end else if (clear) begin
            ps_cnt   <= '0;
            tick_out <= 1'b0;
        end else if (run) begin
            ps_cnt   <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + 1'b1;
            tick_out <= (ps_cnt == PS_LAST);
        end else begin
            tick_out <= 1'b0;
        end
    end

    // ---- Stage p1: step decode and combinational carry chain ----
    assign all_zero = (s0 == '0) && (s1 == '0) && (s2 == '0) && (s3 == '0);
    assign halt     = (HALT_AT_ZERO != 0) && dir && all_zero;

    // clear/load outrank the tick; the tick outranks edit.
    assign tick_go  = tick_out && !clear && !load && !halt;
    assign edit_ok  = !run && (edit_up ^ edit_dn) && !clear && !load && !tick_out;

    assign tick_op  = dir ? DEC : INC;
    assign edit_op  = edit_up ? INC : DEC;
    assign chain_op = tick_go ? tick_op : edit_op;
    // Edits only ripple upward when EDIT_CARRY is set; ticks always ripple.
    assign chain_on = tick_go || (edit_ok && (EDIT_CARRY != 0));

    assign op0 = tick_go                          ? tick_op  :
                 (edit_ok && edit_sel == 2'd0)    ? edit_op  : NONE;
    assign op1 = (edit_ok && edit_sel == 2'd1)    ? edit_op  :
                 (chain_on && wrap0)              ? chain_op : NONE;
    assign op2 = (edit_ok && edit_sel == 2'd2)    ? edit_op  :
                 (chain_on && wrap1)              ? chain_op : NONE;
    assign op3 = (edit_ok && edit_sel == 2'd3)    ? edit_op  :
                 (chain_on && wrap2)              ? chain_op : NONE;

    mod_stage_counter #(.MOD(MOD0), .PRESET(0)) u_stage0 (
        .clk(clk), .reset(reset), .op(op0), .clear(clear), .load(load),
        .ld_val(ld_s0), .value(s0), .wrap(wrap0)
    );

    mod_stage_counter #(.MOD(MOD1), .PRESET(0)) u_stage1 (
        .clk(clk), .reset(reset), .op(op1), .clear(clear), .load(load),
        .ld_val(ld_s1), .value(s1), .wrap(wrap1)
    );

    mod_stage_counter #(.MOD(MOD2), .PRESET(0)) u_stage2 (
        .clk(clk), .reset(reset), .op(op2), .clear(clear), .load(load),
        .ld_val(ld_s2), .value(s2), .wrap(wrap2)
    );

    // Hour carry/borrow out has nowhere to go.
    mod_stage_counter #(.MOD(MOD3), .PRESET(PRESET3)) u_stage3 (
        .clk(clk), .reset(reset), .op(op3), .clear(clear), .load(load),
        .ld_val(ld_s3), .value(s3), .wrap(wrap3_unused)
    );

    // ---- Stage p2: done / alarm pulse generation ----
    assign match = alarm_en && (s1 == al_s1) && (s2 == al_s2) && (s3 == al_s3);

    // dn_step_p0 remembers that the last edge applied a down-tick, so done
    // fires only when a tick (not an edit, clear or load) produced zero and
    // cannot repeat while halted, since halted ticks are not applied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dn_step_p0 <= 1'b0;
            done       <= 1'b0;
            match_p0   <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            dn_step_p0 <= tick_go && dir;
            done       <= dn_step_p0 && all_zero;
            match_p0   <= match;
            alarm      <= match && !match_p0;
        end
    end

endmodule

// File: tb/tb_time_counter_chain.sv
module tb_time_counter_chain;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0, dir = 1'b0, clear = 1'b0, load = 1'b0;
    logic [6:0] ld_s0 = '0;
    logic [5:0] ld_s1 = '0, ld_s2 = '0;
    logic [4:0] ld_s3 = '0;
    logic [1:0] edit_sel = '0;
    logic       edit_up = 1'b0, edit_dn = 1'b0, alarm_en = 1'b0;
    logic [5:0] al_s1 = '0, al_s2 = '0;
    logic [4:0] al_s3 = '0;

    logic [6:0] a_s0, b_s0;
    logic [5:0] a_s1, a_s2, b_s1, b_s2;
    logic [4:0] a_s3, b_s3;
    logic       a_tick, a_done, a_alarm, b_tick, b_done, b_alarm;

    int n_vec = 0, n_err = 0;

    // dut_a: edits wrap locally, hour preset 0
    time_counter_chain #(
        .CLK_HZ(1000), .TICK_HZ(100), .PRESET3(0), .EDIT_CARRY(0), .HALT_AT_ZERO(1)
    ) dut_a (
        .clk(clk), .reset(reset), .run(run), .dir(dir), .clear(clear), .load(load),
        .ld_s0(ld_s0), .ld_s1(ld_s1), .ld_s2(ld_s2), .ld_s3(ld_s3),
        .edit_sel(edit_sel), .edit_up(edit_up), .edit_dn(edit_dn),
        .alarm_en(alarm_en), .al_s1(al_s1), .al_s2(al_s2), .al_s3(al_s3),
        .s0(a_s0), .s1(a_s1), .s2(a_s2), .s3(a_s3),
        .tick_out(a_tick), .done(a_done), .alarm(a_alarm)
    );

    // dut_b: edits ripple, hour preset 7
    time_counter_chain #(
        .CLK_HZ(1000), .TICK_HZ(100), .PRESET3(7), .EDIT_CARRY(1), .HALT_AT_ZERO(1)
    ) dut_b (
        .clk(clk), .reset(reset), .run(run), .dir(dir), .clear(clear), .load(load),
        .ld_s0(ld_s0), .ld_s1(ld_s1), .ld_s2(ld_s2), .ld_s3(ld_s3),
        .edit_sel(edit_sel), .edit_up(edit_up), .edit_dn(edit_dn),
        .alarm_en(alarm_en), .al_s1(al_s1), .al_s2(al_s2), .al_s3(al_s3),
        .s0(b_s0), .s1(b_s1), .s2(b_s2), .s3(b_s3),
        .tick_out(b_tick), .done(b_done), .alarm(b_alarm)
    );

    always #5 clk = ~clk;

    // Pulse counters and alarm-latency bookkeeping, sampled on the falling edge.
    int         cyc_n = 0, a_done_n = 0, b_done_n = 0, a_al_n = 0, b_al_n = 0;
    int         t_s1 = -100, t_al = -1;
    logic [5:0] prev_s1 = '0;
    always @(negedge clk) begin
        cyc_n++;
        if (a_done === 1'b1)  a_done_n++;
        if (b_done === 1'b1)  b_done_n++;
        if (a_alarm === 1'b1) begin a_al_n++; t_al = cyc_n; end
        if (b_alarm === 1'b1) b_al_n++;
        if (a_s1 == 6'd1 && prev_s1 == 6'd0) t_s1 = cyc_n;
        prev_s1 = a_s1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_a(input string tag, input int e0, input int e1, input int e2, input int e3);
        chk({tag, "_a_s0"}, 32'(a_s0), e0);
        chk({tag, "_a_s1"}, 32'(a_s1), e1);
        chk({tag, "_a_s2"}, 32'(a_s2), e2);
        chk({tag, "_a_s3"}, 32'(a_s3), e3);
    endtask

    task automatic chk_b(input string tag, input int e0, input int e1, input int e2, input int e3);
        chk({tag, "_b_s0"}, 32'(b_s0), e0);
        chk({tag, "_b_s1"}, 32'(b_s1), e1);
        chk({tag, "_b_s2"}, 32'(b_s2), e2);
        chk({tag, "_b_s3"}, 32'(b_s3), e3);
    endtask

    // Waits (bounded) for the next falling edge where tick_out is high;
    // k returns the number of falling edges waited.
    task automatic wait_tick(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (a_tick !== 1'b1 && k < 40);
        if (a_tick !== 1'b1) chk("tick_timeout", 32'(a_tick), 32'd1);
    endtask

    task automatic one_tick(input logic d);
        int k;
        dir = d;
        run = 1'b1;
        wait_tick(k);
        run = 1'b0;
        cyc(1);
    endtask

    task automatic do_load(input int v0, input int v1, input int v2, input int v3);
        ld_s0 = 7'(v0); ld_s1 = 6'(v1); ld_s2 = 6'(v2); ld_s3 = 5'(v3);
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic pulse_edit(input int sel, input logic up, input logic dn);
        edit_sel = 2'(sel);
        edit_up  = up;
        edit_dn  = dn;
        cyc(1);
        edit_up  = 1'b0;
        edit_dn  = 1'b0;
    endtask

    initial begin
        int k;
        int d0, db0, al0, bl0;

        // Reset state
        #1 reset = 1'b1;
        cyc(2);
        chk_a("rst", 0, 0, 0, 0);
        chk_b("rst", 0, 0, 0, 7);
        chk("rst_tick", 32'(a_tick), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_alarm", 32'(a_alarm), 0);
        reset = 1'b0;

        // Up count: 6000 ticks = 1 minute, tick period 10 cycles
        dir = 1'b0;
        run = 1'b1;
        wait_tick(k);
        chk("first_tick_lat", k, 10);
        wait_tick(k);
        chk("tick_period", k, 10);
        cyc(59980);
        chk("tick_6000", 32'(a_tick), 1);
        run = 1'b0;
        cyc(1);
        chk_a("up6000", 0, 0, 1, 0);
        chk_b("up6000", 0, 0, 1, 7);

        // Full rollover
        d0 = a_done_n;
        do_load(99, 59, 59, 23);
        one_tick(1'b0);
        chk_a("rollover", 0, 0, 0, 0);
        chk_b("rollover", 0, 0, 0, 0);
        chk("rollover_no_done", a_done_n - d0, 0);

        // Borrow chain
        do_load(0, 0, 0, 1);
        one_tick(1'b1);
        chk_a("borrow", 99, 59, 59, 0);
        chk_b("borrow", 99, 59, 59, 0);

        // Countdown to zero, then 20 halted ticks
        d0  = a_done_n;
        db0 = b_done_n;
        do_load(5, 0, 0, 0);
        dir = 1'b1;
        run = 1'b1;
        repeat (5) wait_tick(k);
        cyc(3);
        chk("cd_done_once", a_done_n - d0, 1);
        repeat (20) wait_tick(k);
        run = 1'b0;
        cyc(3);
        chk_a("cd_hold", 0, 0, 0, 0);
        chk("cd_done_total_a", a_done_n - d0, 1);
        chk("cd_done_total_b", b_done_n - db0, 1);

        // Edit with run = 0
        dir = 1'b0;
        d0  = a_done_n;
        do_load(0, 59, 10, 0);
        pulse_edit(1, 1'b1, 1'b0);
        chk("ed_up_a_s1", 32'(a_s1), 0);
        chk("ed_up_a_s2", 32'(a_s2), 10);
        chk("ed_up_b_s1", 32'(b_s1), 0);
        chk("ed_up_b_s2", 32'(b_s2), 11);
        pulse_edit(0, 1'b0, 1'b1);
        chk_a("ed_dn", 99, 0, 10, 0);
        chk_b("ed_dn", 99, 59, 10, 0);
        pulse_edit(0, 1'b1, 1'b1);
        chk("ed_both_a", 32'(a_s0), 99);
        chk("ed_both_b", 32'(b_s0), 99);
        run = 1'b1;
        pulse_edit(0, 1'b1, 1'b0);
        run = 1'b0;
        chk("ed_run_a", 32'(a_s0), 99);
        chk("ed_run_b", 32'(b_s0), 99);
        chk("ed_no_done", a_done_n - d0, 0);

        // Load saturation
        do_load(120, 63, 63, 31);
        chk_a("sat", 99, 59, 59, 23);

        // clear and load together: preset wins
        ld_s0 = 7'd3; ld_s1 = 6'd4; ld_s2 = 6'd5; ld_s3 = 5'd6;
        clear = 1'b1;
        load  = 1'b1;
        cyc(1);
        clear = 1'b0;
        load  = 1'b0;
        chk_a("clr_ld", 0, 0, 0, 0);
        chk_b("clr_ld", 0, 0, 0, 7);

        // Alarm on 00:00:01, held for 50 ticks
        al_s1 = 6'd1; al_s2 = 6'd0; al_s3 = 5'd0;
        alarm_en = 1'b1;
        al0 = a_al_n;
        bl0 = b_al_n;
        dir = 1'b0;
        run = 1'b1;
        repeat (150) wait_tick(k);
        run = 1'b0;
        cyc(2);
        chk("al_s0", 32'(a_s0), 50);
        chk("al_s1", 32'(a_s1), 1);
        chk("al_once_a", a_al_n - al0, 1);
        chk("al_none_b", b_al_n - bl0, 0);
        chk("al_latency", t_al - t_s1, 1);

        // Match created by clear/load
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        al0 = a_al_n;
        bl0 = b_al_n;
        do_load(0, 1, 0, 0);
        cyc(2);
        chk("al_load_a", a_al_n - al0, 1);
        chk("al_load_b", b_al_n - bl0, 1);
        alarm_en = 1'b0;

        // Async reset mid-count, then clean restart
        do_load(50, 30, 10, 5);
        run = 1'b1;
        cyc(5);
        #2 reset = 1'b1;
        #1;
        chk_a("async_rst", 0, 0, 0, 0);
        chk_b("async_rst", 0, 0, 0, 7);
        chk("async_rst_tick", 32'(a_tick), 0);
        @(negedge clk);
        reset = 1'b0;
        wait_tick(k);
        chk("restart_lat", k, 10);
        run = 1'b0;
        cyc(1);
        chk_a("restart", 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
